gray_counter_param: RTL and testbench

Parametrised N-bit Gray-code counter. It generalises the fixed 2-bit Gray counter FSM with the following features:
- count enable
- up/down direction
- parallel load
- synchronous clear
- wrap or saturate mode
- simultaneous binary output
- terminal-count pulse

It is used as a pointer/sequence generator wherever single-bit-change codes are needed, such as async FIFO pointers and encoder sequencing.

---
 rtl/gray_counter_param.sv | 88 ++++++++
 tb/tb_gray_counter_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter with enable, direction, parallel load, clear,
// wrap/saturate limit handling, a binary copy of the count and a terminal-count pulse.
module gray_counter_param #(
  parameter int WIDTH    = 4,
  parameter bit MODE_SAT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_M1 = MAX - ONE;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_bin_s;
  logic             next_tc_s;

  // Next count and terminal-count decision; priority clr > load > en.
  always_comb begin
    next_bin_s = bin_r;
    next_tc_s  = 1'b0;
    if (clr) begin
      next_bin_s = ZERO;
    end else if (load) begin
      next_bin_s = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (bin_r != MAX) begin
          next_bin_s = bin_r + ONE;
          // In saturate mode the pulse marks arrival at the top limit.
          next_tc_s  = (MODE_SAT == 1'b1) && (bin_r == MAX_M1);
        end else if (MODE_SAT == 1'b0) begin
          next_bin_s = ZERO;
          next_tc_s  = 1'b1;
        end else begin
          next_bin_s = bin_r;
        end
      end else begin
        if (bin_r != ZERO) begin
          next_bin_s = bin_r - ONE;
          next_tc_s  = (MODE_SAT == 1'b1) && (bin_r == ONE);
        end else if (MODE_SAT == 1'b0) begin
          next_bin_s = MAX;
          next_tc_s  = 1'b1;
        end else begin
          next_bin_s = bin_r;
        end
      end
    end else begin
      next_bin_s = bin_r;
    end
  end

  // Count, Gray copy and pulse registers; Gray is encoded from the next count
  // so both outputs always show the same value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_r  <= ZERO;
      gray_r <= ZERO;
      tc_r   <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= bin2gray(next_bin_s);
      tc_r   <= next_tc_s;
    end
  end

  assign bin_out  = bin_r;
  assign gray_out = gray_r;
  assign tc       = tc_r;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: three instances (2-bit wrap, 4-bit wrap,
// 3-bit saturate), directed vectors with hand-computed results plus a model-checked run.
module tb_gray_counter_param;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic en_a, up_a, ld_a, clr_a, tc_a;
  logic [1:0] lv_a, g_a, b_a;
  logic en_b, up_b, ld_b, clr_b, tc_b;
  logic [3:0] lv_b, g_b, b_b;
  logic en_c, up_c, ld_c, clr_c, tc_c;
  logic [2:0] lv_c, g_c, b_c;

  gray_counter_param #(.WIDTH(2), .MODE_SAT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .load(ld_a), .load_val(lv_a),
    .clr(clr_a), .gray_out(g_a), .bin_out(b_a), .tc(tc_a));
  gray_counter_param #(.WIDTH(4), .MODE_SAT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .load(ld_b), .load_val(lv_b),
    .clr(clr_b), .gray_out(g_b), .bin_out(b_b), .tc(tc_b));
  gray_counter_param #(.WIDTH(3), .MODE_SAT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .up_dn(up_c), .load(ld_c), .load_val(lv_c),
    .clr(clr_c), .gray_out(g_c), .bin_out(b_c), .tc(tc_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    bit         step;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  logic [3:0] last_gray [3] = '{4'd0, 4'd0, 4'd0};

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check(input int d, input exp_t e, input logic [3:0] b,
                       input logic [3:0] g, input logic t);
    string tag;
    tag = $sformatf("dut%0d", d);
    compared++;
    if (e.due != cyc) begin
      mismatched++;
      $display("FAIL %s stale entry: due cycle %0d, now %0d", tag, e.due, cyc);
    end
    cmp({tag, " bin_out"}, b, e.bin);
    cmp({tag, " gray_out"}, g, e.gray);
    cmp({tag, " tc"}, {3'd0, t}, {3'd0, e.tc});
    if (e.step) cmp({tag, " gray bits changed"}, 4'($countones(g ^ last_gray[d])), 4'd1);
    last_gray[d] = g;
  endtask

  // Monitor: pop every expectation due on this cycle and compare it with the outputs.
  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      check(0, e, {2'd0, b_a}, {2'd0, g_a}, tc_a);
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      e = qb.pop_front();
      check(1, e, b_b, g_b, tc_b);
    end
    while (qc.size() > 0 && qc[0].due <= cyc) begin
      e = qc.pop_front();
      check(2, e, {1'b0, b_c}, {1'b0, g_c}, tc_c);
    end
  end

  task automatic set_in(input int d, input bit e, input bit u, input bit l,
                        input bit c, input logic [3:0] v);
    {en_a, up_a, ld_a, clr_a, lv_a} = '0;
    {en_b, up_b, ld_b, clr_b, lv_b} = '0;
    {en_c, up_c, ld_c, clr_c, lv_c} = '0;
    case (d)
      0: begin en_a = e; up_a = u; ld_a = l; clr_a = c; lv_a = v[1:0]; end
      1: begin en_b = e; up_b = u; ld_b = l; clr_b = c; lv_b = v; end
      2: begin en_c = e; up_c = u; ld_c = l; clr_c = c; lv_c = v[2:0]; end
      default: ;
    endcase
  endtask

  task automatic push(input int d, input logic [3:0] b, input logic [3:0] g,
                      input logic t, input bit s);
    exp_t e;
    e.due = cyc + 1; e.bin = b; e.gray = g; e.tc = t; e.step = s;
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      2: qc.push_back(e);
      default: ;
    endcase
  endtask

  // One clock: drive controls on the falling edge, queue the result of the next rising edge.
  task automatic step(input int d, input bit e, input bit u, input bit l, input bit c,
                      input logic [3:0] v, input logic [3:0] b, input logic [3:0] g,
                      input logic t, input bit s);
    @(negedge clk);
    set_in(d, e, u, l, c, v);
    push(d, b, g, t, s);
  endtask

  initial begin
    logic [3:0] m, nm, v;
    logic       t;
    bit         e, u, l, c;
    int         w;

    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    cmp("reset gray_a", {2'd0, g_a}, 4'b0000);
    cmp("reset bin_a", {2'd0, b_a}, 4'd0);
    cmp("reset tc_a", {3'd0, tc_a}, 4'd0);
    cmp("reset bin_b", b_b, 4'd0);
    cmp("reset gray_c", {1'b0, g_c}, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2-bit wrap, counting up through the wrap
    step(0, 1, 1, 0, 0, 4'd0, 4'd1, 4'b0001, 1'b0, 1);
    step(0, 1, 1, 0, 0, 4'd0, 4'd2, 4'b0011, 1'b0, 1);
    step(0, 1, 1, 0, 0, 4'd0, 4'd3, 4'b0010, 1'b0, 1);
    step(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'b0000, 1'b1, 1);
    step(0, 1, 1, 0, 0, 4'd0, 4'd1, 4'b0001, 1'b0, 1);
    step(0, 0, 1, 0, 0, 4'd0, 4'd1, 4'b0001, 1'b0, 0);

    // 4-bit wrap: load 7, count down through the wrap, then back up through it
    step(1, 0, 0, 1, 0, 4'd7, 4'd7,  4'b0100, 1'b0, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd6,  4'b0101, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd5,  4'b0111, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd4,  4'b0110, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd3,  4'b0010, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd2,  4'b0011, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd1,  4'b0001, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0,  4'b0000, 1'b0, 1);
    step(1, 1, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 1'b1, 1);
    step(1, 0, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 1'b0, 0);
    step(1, 1, 1, 0, 0, 4'd0, 4'd0,  4'b0000, 1'b1, 1);

    // 3-bit saturate: pulse on arrival at a limit, no pulse while held there
    step(2, 0, 0, 1, 0, 4'd6, 4'd6, 4'b0101, 1'b0, 0);
    step(2, 1, 1, 0, 0, 4'd0, 4'd7, 4'b0100, 1'b1, 1);
    step(2, 1, 1, 0, 0, 4'd0, 4'd7, 4'b0100, 1'b0, 0);
    step(2, 1, 1, 0, 0, 4'd0, 4'd7, 4'b0100, 1'b0, 0);
    step(2, 0, 0, 1, 0, 4'd2, 4'd2, 4'b0011, 1'b0, 0);
    step(2, 1, 0, 0, 0, 4'd0, 4'd1, 4'b0001, 1'b0, 1);
    step(2, 1, 0, 0, 0, 4'd0, 4'd0, 4'b0000, 1'b1, 1);
    step(2, 1, 0, 0, 0, 4'd0, 4'd0, 4'b0000, 1'b0, 0);
    step(2, 1, 1, 0, 0, 4'd0, 4'd1, 4'b0001, 1'b0, 1);

    // Priority clr > load > en
    step(1, 0, 0, 1, 0, 4'd5, 4'd5, 4'b0111, 1'b0, 0);
    step(1, 1, 1, 1, 1, 4'd3, 4'd0, 4'b0000, 1'b0, 0);
    step(1, 1, 1, 1, 0, 4'd3, 4'd3, 4'b0010, 1'b0, 0);

    // Mid-count asynchronous reset
    step(1, 0, 0, 1, 0, 4'd7, 4'd7, 4'b0100, 1'b0, 0);
    step(1, 1, 1, 0, 0, 4'd0, 4'd8, 4'b1100, 1'b0, 1);
    step(1, 1, 1, 0, 0, 4'd0, 4'd9, 4'b1101, 1'b0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("async reset bin_b", b_b, 4'd0);
    cmp("async reset gray_b", g_b, 4'd0);
    cmp("async reset tc_b", {3'd0, tc_b}, 4'd0);
    @(negedge clk);
    cmp("reset held bin_b", b_b, 4'd0);
    rst = 1'b0;
    push(1, 4'd1, 4'b0001, 1'b0, 0);
    step(1, 1, 1, 0, 0, 4'd0, 4'd2, 4'b0011, 1'b0, 1);

    // Model-checked mixed run on the 4-bit wrap instance
    m = 4'd2;
    for (int i = 0; i < 200; i++) begin
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1);
      l = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 24) == 0);
      v = 4'($urandom_range(0, 15));
      t = 1'b0;
      if (c) nm = 4'd0;
      else if (l) nm = v;
      else if (e && u) begin nm = 4'(m + 4'd1); t = (m == 4'd15); end
      else if (e) begin nm = 4'(m - 4'd1); t = (m == 4'd0); end
      else nm = m;
      step(1, e, u, l, c, v, nm, nm ^ (nm >> 1), t, e && !l && !c);
      m = nm;
    end

    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    w = 0;
    while ((qa.size() + qb.size() + qc.size()) > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if ((qa.size() + qb.size() + qc.size()) > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations never compared, expected 0",
               qa.size() + qb.size() + qc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
